game_controller: RTL and testbench

Top-level game sequencer for the bomb: owns and drives the 8-bit `game_state` bus that the countdown block consumes. It watches the three BCD countdown digits, per-module solved flags and strike pulses. It decides whether the round is defused or exploded, and it returns to idle on the player's start button.

---
 rtl/bombsquad_pkg.sv | 23 ++
 rtl/button_edge.sv | 23 ++
 rtl/game_controller.sv | 133 +++++++++++++
 tb/tb_game_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bombsquad_pkg.sv
// bombsquad_pkg: shared game-state codes and BCD digit width for the
// controller, countdown and display blocks.
package bombsquad_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [7:0] {
        GS_IDLE     = 8'h00,
        GS_RUN      = 8'h10,
        GS_DEFUSED  = 8'h20,
        GS_EXPLODED = 8'h30
    } game_state_e;

    // Literal compare: non-BCD patterns never count as zero.
    function automatic logic bcd_is_zero(
        input logic [BCD_W-1:0] d2,
        input logic [BCD_W-1:0] d1,
        input logic [BCD_W-1:0] d0
    );
        return (d2 == '0) && (d1 == '0) && (d0 == '0);
    endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge: 2-flop synchronizer plus falling-edge detector for a raw
// active-low button. Ports: clk, reset (async low), btn_n in, press_p out.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_p
);

    // [0],[1] synchronize; [2] is the previous synchronized sample.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], btn_n};
        end
    end

    assign press_p = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/game_controller.sv
// game_controller: round sequencer IDLE/RUN/DEFUSED/EXPLODED driving game_state.
// Ports: clk, reset (async low), start_n, value_three/two/one (BCD),
// modules_solved, strike in; game_state, strike_count, time_zero out.
// Build option: STRIKE_LIMIT_EN enables strike counting and strike explosion.
module game_controller
    import bombsquad_pkg::*;
#(
    parameter int NUM_MODULES = 3,
    parameter int STRIKE_MAX  = 3,
    parameter int ARM_GUARD   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_n,
    input  logic [BCD_W-1:0]       value_three,
    input  logic [BCD_W-1:0]       value_two,
    input  logic [BCD_W-1:0]       value_one,
    input  logic [NUM_MODULES-1:0] modules_solved,
    input  logic                   strike,
    output logic [7:0]             game_state,
    output logic [1:0]             strike_count,
    output logic                   time_zero
);

    localparam logic [3:0] GUARD_LOAD = 4'(ARM_GUARD);

    game_state_e state_q, state_d;
    logic        start_p;
    logic        digits_zero;
    logic        all_solved;
    logic        guard_done;
    logic        strike_out;
    logic        arm;
    logic [3:0]  guard_q;

    button_edge u_start (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (start_n),
        .press_p (start_p)
    );

    assign digits_zero = bcd_is_zero(value_three, value_two, value_one);
    assign all_solved  = &modules_solved;
    assign guard_done  = (guard_q == 4'd0);
    assign arm         = (state_q == GS_IDLE) && start_p;

`ifdef STRIKE_LIMIT_EN
    localparam logic [1:0] SMAX = 2'(STRIKE_MAX);

    logic [1:0] strikes_q;
    logic [1:0] strikes_d;
    logic [2:0] strike_sum;

    // Sum includes this cycle's pulse so the final strike ends the round
    // on its own edge.
    assign strike_sum = {1'b0, strikes_q} + {2'b00, strike};
    assign strike_out = (strike_sum >= {1'b0, SMAX});
    assign strikes_d  = strike_out ? SMAX : strike_sum[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strikes_q <= 2'd0;
        end else if (arm) begin
            strikes_q <= 2'd0;
        end else if (state_q == GS_RUN) begin
            strikes_q <= strikes_d;
        end
    end

    assign strike_count = strikes_q;
`else
    logic unused_strike;

    assign unused_strike = strike;
    assign strike_out    = 1'b0;
    assign strike_count  = 2'd0;
`endif

    // Guard masks stale 000 digits left over from the previous round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            guard_q <= 4'd0;
        end else if (arm) begin
            guard_q <= GUARD_LOAD;
        end else if ((state_q == GS_RUN) && !guard_done) begin
            guard_q <= guard_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_zero <= 1'b0;
        end else begin
            time_zero <= digits_zero;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= GS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GS_IDLE: begin
                if (start_p) state_d = GS_RUN;
            end
            GS_RUN: begin
                if (guard_done) begin
                    if (all_solved) begin
                        state_d = GS_DEFUSED;
                    end else if (digits_zero || strike_out) begin
                        state_d = GS_EXPLODED;
                    end
                end
            end
            GS_DEFUSED, GS_EXPLODED: begin
                if (start_p) state_d = GS_IDLE;
            end
            default: state_d = GS_IDLE;
        endcase
    end

    always_comb begin
        game_state = state_q;
    end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed round scenarios plus random stimulus,
// checked against a cycle-level behavioural model of the game rules.
module tb_game_controller;

    localparam int NM   = 3;
    localparam int SMAX = 3;
    localparam int AG   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_n;
    logic [3:0] v3, v2, v1;
    logic [2:0] solved;
    logic       strike;
    logic [7:0] game_state;
    logic [1:0] strike_count;
    logic       time_zero;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0 idle,1 run,2 defused,3 exploded
    int m_mode, m_strikes, m_age;
    bit m_tz;
    bit h0, h1, h2;

    always #5 clk = ~clk;

    game_controller #(
        .NUM_MODULES (NM),
        .STRIKE_MAX  (SMAX),
        .ARM_GUARD   (AG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_n        (start_n),
        .value_three    (v3),
        .value_two      (v2),
        .value_one      (v1),
        .modules_solved (solved),
        .strike         (strike),
        .game_state     (game_state),
        .strike_count   (strike_count),
        .time_zero      (time_zero)
    );

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_strikes = 0;
        m_age     = 0;
        m_tz      = 1'b0;
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    endtask

    // Advance the model by one rising edge using the inputs now driven.
    task automatic model_step();
        bit press;
        bit zero;
        int sum;
        press = h2 && !h1;
        zero  = (v3 == 4'd0) && (v2 == 4'd0) && (v1 == 4'd0);
        case (m_mode)
            0: begin
                if (press) begin
                    m_mode = 1; m_strikes = 0; m_age = 0;
                end
            end
            1: begin
`ifdef STRIKE_LIMIT_EN
                sum = m_strikes + int'(strike);
`else
                sum = 0;
`endif
                if (m_age >= AG) begin
                    if (solved == 3'b111) m_mode = 2;
                    else if (zero || sum >= SMAX) m_mode = 3;
                end
                m_strikes = (sum > SMAX) ? SMAX : sum;
                if (m_age < 1000) m_age++;
            end
            default: begin
                if (press) m_mode = 0;
            end
        endcase
        m_tz = zero;
        h2 = h1; h1 = h0; h0 = start_n;
    endtask

    task automatic compare();
        check("game_state", game_state, 8'(m_mode * 16));
        check("strike_count", {6'd0, strike_count}, 8'(m_strikes));
        check("time_zero", {7'd0, time_zero}, {7'd0, m_tz});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic set_dig(input logic [11:0] d);
        {v3, v2, v1} = d;
    endtask

    task automatic press();
        start_n = 1'b0; tick();
        start_n = 1'b1; tick(); tick();
    endtask

    initial begin
        reset = 1'b0; start_n = 1'b1; strike = 1'b0;
        solved = 3'b000; set_dig(12'h000);
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst_gs", game_state, 8'h00);
        check("rst_sc", {6'd0, strike_count}, 8'h00);
        check("rst_tz", {7'd0, time_zero}, 8'h00);
        reset = 1'b1;

        // start with stale 000 digits; guard must hold off explosion
        press();
        check("start_run", game_state, 8'h10);
        tick(); tick();
        set_dig(12'h200);
        tick(); tick(); tick();
        check("guard_hold", game_state, 8'h10);
        set_dig(12'h001); tick();
        set_dig(12'h000); tick();
        check("timeout_gs", game_state, 8'h30);
        check("timeout_tz", {7'd0, time_zero}, 8'h01);

        // solve a round
        set_dig(12'h200);
        press();
        check("back_idle", game_state, 8'h00);
        press();
        tick(); tick(); tick();
        solved = 3'b111; tick();
        check("defused", game_state, 8'h20);
        check("defused_sc", {6'd0, strike_count}, 8'h00);
        solved = 3'b000;

        // strike out
        press(); press();
        tick(); tick(); tick();
        strike = 1'b1;
        tick();
`ifdef STRIKE_LIMIT_EN
        check("strike1", {6'd0, strike_count}, 8'h01);
`else
        check("strike1", {6'd0, strike_count}, 8'h00);
`endif
        tick();
        tick();
`ifdef STRIKE_LIMIT_EN
        check("strike3_sc", {6'd0, strike_count}, 8'h03);
        check("strike3_gs", game_state, 8'h30);
`else
        check("strike3_sc", {6'd0, strike_count}, 8'h00);
        check("strike3_gs", game_state, 8'h10);
`endif
        strike = 1'b0;
        solved = 3'b111; tick();
        solved = 3'b000;

        // solve and zero together: defused wins
        press(); press();
        tick(); tick(); tick();
        solved = 3'b111; set_dig(12'h000); tick();
        check("solve_zero", game_state, 8'h20);
        solved = 3'b000; set_dig(12'h150);
        press();
        check("to_idle", game_state, 8'h00);
        press();
        check("rearm_gs", game_state, 8'h10);
        check("rearm_sc", {6'd0, strike_count}, 8'h00);

        // async reset mid-round
        tick(); tick(); tick();
        strike = 1'b1; tick(); tick();
        strike = 1'b0; tick();
        #2 reset = 1'b0;
        #1;
        check("async_gs", game_state, 8'h00);
        check("async_sc", {6'd0, strike_count}, 8'h00);
        check("async_tz", {7'd0, time_zero}, 8'h00);
        model_reset();
        start_n = 1'b0; set_dig(12'h000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            compare();
        end
        start_n = 1'b1;
        reset = 1'b1;

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) start_n = ~start_n;
            if ($urandom_range(0, 11) == 0) set_dig(12'h000);
            else set_dig(12'($urandom));
            solved = ($urandom_range(0, 15) == 0) ? 3'b111
                                                  : 3'($urandom_range(0, 6));
            strike = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
